// File: rtl/fifo_addr_sched.sv
// ============================================================================
// fifo_addr_sched : shared delay-FIFO address counters for NTT/INTT datapaths
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_addr_sched #(
    parameter  int NTT_STAGE_CNT = 8,
    parameter  int MUL_STAGE_CNT = 4,
    localparam int N   = NTT_STAGE_CNT,
    localparam int F0  = 1 << (N - 2),
    localparam int AW  = $clog2((F0 > MUL_STAGE_CNT) ? F0 : MUL_STAGE_CNT),
    localparam int MW  = ($clog2(MUL_STAGE_CNT - 1) > 1) ? $clog2(MUL_STAGE_CNT - 1) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ntt_req,
    input  logic            intt_req,
    input  logic [N-1:0]    ntt_en,
    input  logic [N-1:0]    intt_en,
    output logic            ntt_gnt,
    output logic            intt_gnt,
    output logic [N-1:0]    stage_en,
    output logic [N*AW-1:0] fifo2_addr,
    output logic [MW-1:0]   fifom_addr,
    output logic            busy
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_NTT  = 2'd1,
        OWN_INTT = 2'd2
    } owner_e;

    owner_e owner_q;
    logic   last_intt_q;
    logic   grant_new;

    function automatic int fifo2_depth(input int idx);
        if (idx < N - 1) begin
            return 1 << (N - 2 - idx);
        end
        return 1;
    endfunction

    // Round robin: on simultaneous requests the client that did not own last wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q     <= OWN_IDLE;
            last_intt_q <= 1'b1;
        end else begin
            case (owner_q)
                OWN_IDLE: begin
                    if (ntt_req && intt_req) begin
                        owner_q <= last_intt_q ? OWN_NTT : OWN_INTT;
                    end else if (ntt_req) begin
                        owner_q <= OWN_NTT;
                    end else if (intt_req) begin
                        owner_q <= OWN_INTT;
                    end
                end
                OWN_NTT: begin
                    if (!ntt_req && (ntt_en == '0)) begin
                        owner_q     <= OWN_IDLE;
                        last_intt_q <= 1'b0;
                    end
                end
                OWN_INTT: begin
                    if (!intt_req && (intt_en == '0)) begin
                        owner_q     <= OWN_IDLE;
                        last_intt_q <= 1'b1;
                    end
                end
                default: owner_q <= OWN_IDLE;
            endcase
        end
    end

    assign ntt_gnt   = (owner_q == OWN_NTT);
    assign intt_gnt  = (owner_q == OWN_INTT);
    assign busy      = (owner_q != OWN_IDLE);
    assign grant_new = (owner_q == OWN_IDLE) && (ntt_req || intt_req);

    // NTT stage k shares the physical FIFO of INTT stage N-1-k.
    always_comb begin
        stage_en = '0;
        case (owner_q)
            OWN_NTT: begin
                for (int i = 0; i < N; i++) begin
                    stage_en[i] = ntt_en[N-1-i];
                end
            end
            OWN_INTT: stage_en = intt_en;
            default:  stage_en = '0;
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_fifo2
        localparam int            DEPTH = fifo2_depth(gi);
        localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

        logic [AW-1:0] cnt_q;
        logic [AW-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (grant_new) begin
                cnt_d = '0;
            end else if (stage_en[gi]) begin
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + AW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign fifo2_addr[gi*AW +: AW] = cnt_q;
    end

    localparam logic [MW-1:0] FM_LAST = MW'(MUL_STAGE_CNT - 2);

    logic [MW-1:0] fm_q;
    logic [MW-1:0] fm_d;

    always_comb begin
        fm_d = fm_q;
        if (grant_new) begin
            fm_d = '0;
        end else if (|stage_en) begin
            fm_d = (fm_q == FM_LAST) ? '0 : fm_q + MW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fm_q <= '0;
        end else begin
            fm_q <= fm_d;
        end
    end

    assign fifom_addr = fm_q;

endmodule

`default_nettype wire
